// File: rtl/div_arb.sv
`default_nettype none
// ============================================================================
// Module   : div_arb
// Brief    : Two-requester round-robin arbiter/sequencer for the shared divider.
//            Optional completion timeout enabled by defining DIV_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module div_arb #(
   parameter int N      = 8,
   parameter int TO_CYC = 300
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic         ack0,
   output logic         ack1,
   output logic         done0,
   output logic         done1,
   output logic [N-1:0] res_q,
   output logic [N-1:0] res_r,
   output logic         res_err,
   output logic         busy,
   output logic [N-1:0] div_a,
   output logic [N-1:0] div_b,
   output logic         div_strt,
   input  logic [N-1:0] div_out,
   input  logic [N-1:0] div_mod,
   input  logic         div_rdy,
   input  logic         div_err
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      BLANK = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t         r_state;
   logic           r_last;
   logic           r_gid;
   logic           r_blank;
   logic [N-1:0]   r_op_a;
   logic [N-1:0]   r_op_b;

   logic           w_gnt0;
   logic           w_gnt1;
   logic           w_fin;
   logic           w_to;

   // On a tie the requester not served last wins; a lone request always wins.
   assign w_gnt1 = req1 & (~req0 | ~r_last);
   assign w_gnt0 = req0 & ~w_gnt1;
   assign w_fin  = div_rdy | div_err;

   // Ack is the same-cycle handshake of the IDLE grant; masked while in reset.
   assign ack0 = (r_state == IDLE) & w_gnt0 & ~rst;
   assign ack1 = (r_state == IDLE) & w_gnt1 & ~rst;

   assign div_a = r_op_a;
   assign div_b = r_op_b;

`ifdef DIV_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TO_CYC + 1);
   logic [CW-1:0]  r_to_cnt;
   assign w_to = (r_to_cnt >= CW'(TO_CYC));
`else
   assign w_to = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_gid    <= 1'b0;
         r_blank  <= 1'b0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         res_q    <= '0;
         res_r    <= '0;
         res_err  <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         div_strt <= 1'b0;
         busy     <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
         r_to_cnt <= '0;
`endif
      end else begin
         done0    <= 1'b0;
         done1    <= 1'b0;
         div_strt <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req0 | req1) begin
                  r_gid    <= w_gnt1;
                  r_last   <= w_gnt1;
                  r_op_a   <= w_gnt1 ? a1 : a0;
                  r_op_b   <= w_gnt1 ? b1 : b0;
                  div_strt <= 1'b1;
                  busy     <= 1'b1;
                  r_state  <= ISSUE;
`ifdef DIV_ARB_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
            end
            ISSUE: begin
               r_blank <= 1'b0;
               r_state <= BLANK;
            end
            BLANK: begin
               // Divider outputs still reflect the previous operation here.
               r_blank <= 1'b1;
               if (r_blank) begin
                  r_state <= WAIT;
               end
`ifdef DIV_ARB_TIMEOUT_EN
               r_to_cnt <= r_to_cnt + CW'(1);
`endif
            end
            WAIT: begin
               if (w_fin) begin
                  res_q   <= div_out;
                  res_r   <= div_mod;
                  res_err <= div_err;
                  done0   <= ~r_gid;
                  done1   <= r_gid;
                  r_state <= DONE;
               end else if (w_to) begin
                  res_q   <= '1;
                  res_r   <= '1;
                  res_err <= 1'b1;
                  done0   <= ~r_gid;
                  done1   <= r_gid;
                  r_state <= DONE;
               end else begin
`ifdef DIV_ARB_TIMEOUT_EN
                  r_to_cnt <= r_to_cnt + CW'(1);
`endif
               end
            end
            DONE: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
